tile_pixel_serializer: RTL and testbench

- Parametrised successor to the two-plane pixel shifter: PLANES bitplanes of WIDTH bits each, serialised into one PLANES-bit pixel per clock-enable.
- Adds a one-entry load buffer with valid/ready handshake, so consecutive words stream with no gap.
- Adds a per-word horizontal flip, latched at transfer, plus an internal bit counter, an underflow strobe and a synchronous flush.
- Sits between the tile/sprite ROM fetch logic and the palette lookup in the video path.

---
 rtl/tile_pixel_serializer.sv | 134 +++++++++++++
 tb/tb_tile_pixel_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_pixel_serializer.sv
// Multi-plane pixel serializer for the tile/sprite video path.
// Takes PLANES bitplanes of WIDTH bits through a one-entry load buffer, then emits one
// PLANES-bit pixel per clock-enable. Consecutive words play with no gap, and each word
// carries its own horizontal flip.
module tile_pixel_serializer #(
  parameter int unsigned PLANES = 2,
  parameter int unsigned WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      n_clr,
  input  logic                      cen_i,
  input  logic                      flush_i,
  input  logic                      ld_valid_i,
  output logic                      ld_ready_o,
  input  logic [PLANES*WIDTH-1:0]   ld_data_i,
  input  logic                      ld_flip_i,
  output logic [PLANES-1:0]         pix_o,
  output logic                      pix_valid_o,
  output logic                      underflow_o
);

  localparam int unsigned DataW = PLANES * WIDTH;
  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [DataW-1:0] buf_data_q, buf_data_d;
  logic             buf_flip_q, buf_flip_d;
  logic             buf_full_q, buf_full_d;
  logic [DataW-1:0] sr_q, sr_d;
  logic             flip_q, flip_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             underflow_q, underflow_d;

  logic [DataW-1:0] sr_shift;
  logic             last_pix;
  logic             do_xfer;

  assign last_pix = active_q && (cnt_q == CntLast);
  // Refill on the cen edge that ends the current word, so the next word follows with no gap.
  assign do_xfer  = cen_i && buf_full_q && (!active_q || last_pix);

  // Advance every plane by one pixel in the direction set by the word's flip.
  always_comb begin
    sr_shift = '0;
    for (int unsigned p = 0; p < PLANES; p++) begin
      if (flip_q) begin
        sr_shift[p*WIDTH +: WIDTH] = sr_q[p*WIDTH +: WIDTH] >> 1;
      end else begin
        sr_shift[p*WIDTH +: WIDTH] = sr_q[p*WIDTH +: WIDTH] << 1;
      end
    end
  end

  // Next state: flush wins, then buffer accept, then transfer, shift or end of word.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_flip_d  = buf_flip_q;
    buf_full_d  = buf_full_q;
    sr_d        = sr_q;
    flip_d      = flip_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    underflow_d = 1'b0;

    if (flush_i) begin
      buf_full_d = 1'b0;
      active_d   = 1'b0;
      sr_d       = '0;
      cnt_d      = '0;
    end else begin
      // The buffer accepts regardless of cen.
      if (ld_valid_i && !buf_full_q) begin
        buf_data_d = ld_data_i;
        buf_flip_d = ld_flip_i;
        buf_full_d = 1'b1;
      end

      if (do_xfer) begin
        sr_d       = buf_data_q;
        flip_d     = buf_flip_q;
        cnt_d      = '0;
        active_d   = 1'b1;
        buf_full_d = 1'b0;
      end else if (cen_i && active_q) begin
        if (last_pix) begin
          // The word ended and nothing is waiting behind it.
          active_d    = 1'b0;
          sr_d        = '0;
          underflow_d = 1'b1;
        end else begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      buf_data_q  <= '0;
      buf_flip_q  <= 1'b0;
      buf_full_q  <= 1'b0;
      sr_q        <= '0;
      flip_q      <= 1'b0;
      cnt_q       <= '0;
      active_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_flip_q  <= buf_flip_d;
      buf_full_q  <= buf_full_d;
      sr_q        <= sr_d;
      flip_q      <= flip_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      underflow_q <= underflow_d;
    end
  end

  // The pixel is taken from the outgoing end of each plane, so it follows the word's flip.
  always_comb begin
    pix_o = '0;
    for (int unsigned p = 0; p < PLANES; p++) begin
      pix_o[p] = flip_q ? sr_q[p*WIDTH] : sr_q[p*WIDTH + WIDTH - 1];
    end
  end

  assign pix_valid_o = active_q;
  assign underflow_o = underflow_q;
  assign ld_ready_o  = !buf_full_q;

endmodule

// File: tb/tb_tile_pixel_serializer.sv
// Scoreboard bench for tile_pixel_serializer (PLANES=2, WIDTH=8).
// Stimulus queues the hand-computed pixels of each word; a negedge monitor compares them with
// every displayed pixel and pops one per cen edge.
module tb_tile_pixel_serializer;

  typedef logic [1:0] pix8_t [8];

  logic        clk = 1'b0;
  logic        n_clr;
  logic        cen_i;
  logic        flush_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [15:0] ld_data_i;
  logic        ld_flip_i;
  logic [1:0]  pix_o;
  logic        pix_valid_o;
  logic        underflow_o;

  int errors = 0;
  int checks = 0;
  int uf_cnt = 0;
  int ph = 0;
  bit cen_div = 1'b0;
  logic [1:0] exp_q[$];

  tile_pixel_serializer #(
    .PLANES(2),
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .n_clr      (n_clr),
    .cen_i      (cen_i),
    .flush_i    (flush_i),
    .ld_valid_i (ld_valid_i),
    .ld_ready_o (ld_ready_o),
    .ld_data_i  (ld_data_i),
    .ld_flip_i  (ld_flip_i),
    .pix_o      (pix_o),
    .pix_valid_o(pix_valid_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: each displayed pixel must match the head of the queue; a cen edge consumes it.
  always @(negedge clk) begin
    if (underflow_o) uf_cnt++;
    if (pix_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix_unexpected: got pix=%0d with pix_valid=1, expected no pixel", pix_o);
      end else begin
        check("pix", int'(pix_o), int'(exp_q[0]));
        if (cen_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (cen_div) begin
      ph = (ph + 1) % 3;
      cen_i = (ph == 0);
    end
  endtask

  task automatic push8(input pix8_t e);
    foreach (e[i]) exp_q.push_back(e[i]);
  endtask

  task automatic load(input logic [7:0] p0, input logic [7:0] p1, input logic f);
    int n = 0;
    ld_valid_i = 1'b1;
    ld_data_i  = {p1, p0};
    ld_flip_i  = f;
    while (!ld_ready_o && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: ld_ready stayed 0 for %0d cycles, expected 1", n);
    end
    tick();
    ld_valid_i = 1'b0;
  endtask

  task automatic drain(output int gaps);
    int n = 0;
    gaps = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
      if (exp_q.size() != 0 && !pix_valid_o) gaps++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d pixels still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int u0;
    int g;
    int n;

    n_clr      = 1'b0;
    cen_i      = 1'b0;
    flush_i    = 1'b0;
    ld_valid_i = 1'b0;
    ld_data_i  = '0;
    ld_flip_i  = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      cen_i      = 1'($urandom);
      flush_i    = 1'($urandom);
      ld_valid_i = 1'($urandom);
      ld_data_i  = 16'($urandom);
      ld_flip_i  = 1'($urandom);
      #1;
      check("rst_pix", int'(pix_o), 0);
      check("rst_valid", int'(pix_valid_o), 0);
      check("rst_underflow", int'(underflow_o), 0);
      check("rst_ready", int'(ld_ready_o), 1);
    end
    ld_valid_i = 1'b0;
    flush_i    = 1'b0;
    cen_i      = 1'b1;
    #1;
    n_clr = 1'b1;
    u0 = uf_cnt;
    repeat (20) tick();
    check("idle_no_underflow", uf_cnt - u0, 0);
    check("idle_valid", int'(pix_valid_o), 0);

    // Normal order.
    push8('{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd3});
    u0 = uf_cnt;
    load(8'hC1, 8'h0F, 1'b0);
    drain(g);
    check("norm_end_valid", int'(pix_valid_o), 0);
    check("norm_end_underflow", int'(underflow_o), 1);
    tick();
    check("norm_underflow_clear", int'(underflow_o), 0);
    check("norm_underflow_count", uf_cnt - u0, 1);

    // Flipped.
    push8('{2'd3, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1});
    u0 = uf_cnt;
    load(8'hC1, 8'h0F, 1'b1);
    drain(g);
    check("flip_end_valid", int'(pix_valid_o), 0);
    check("flip_end_underflow", int'(underflow_o), 1);
    tick();
    check("flip_underflow_count", uf_cnt - u0, 1);

    // Back-to-back: A unflipped, B = planes A5/3C flipped.
    push8('{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd3});
    push8('{2'd1, 2'd0, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1});
    u0 = uf_cnt;
    load(8'hC1, 8'h0F, 1'b0);
    load(8'hA5, 8'h3C, 1'b1);
    n = 0;
    while (!ld_ready_o && n < 50) begin
      n++;
      tick();
    end
    check("b2b_ready_low_cycles", n, 7);
    check("b2b_seam_valid", int'(pix_valid_o), 1);
    check("b2b_seam_underflow", int'(underflow_o), 0);
    drain(g);
    check("b2b_gaps", g, 0);
    check("b2b_no_early_underflow", uf_cnt - u0, 0);
    tick();
    check("b2b_underflow_after_b", uf_cnt - u0, 1);

    // cen every third clk; accept lands on a cen=0 edge.
    cen_div = 1'b1;
    n = 0;
    while (cen_i && n < 5) begin
      tick();
      n++;
    end
    push8('{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd3});
    u0 = uf_cnt;
    load(8'hC1, 8'h0F, 1'b0);
    check("gate_ready_drop", int'(ld_ready_o), 0);
    drain(g);
    repeat (4) tick();
    check("gate_underflow_count", uf_cnt - u0, 1);
    cen_div = 1'b0;
    cen_i   = 1'b1;
    repeat (2) tick();

    // Flush after 3 pixels with a word buffered.
    u0 = uf_cnt;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    ld_valid_i = 1'b1;
    ld_data_i  = {8'h0F, 8'hC1};
    ld_flip_i  = 1'b0;
    tick();
    ld_data_i = {8'h3C, 8'hA5};
    ld_flip_i = 1'b1;
    tick();
    tick();
    ld_valid_i = 1'b0;
    tick();
    check("flush_word_buffered", int'(ld_ready_o), 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_valid", int'(pix_valid_o), 0);
    check("flush_pix", int'(pix_o), 0);
    check("flush_ready", int'(ld_ready_o), 1);
    repeat (12) tick();
    check("flush_no_underflow", uf_cnt - u0, 0);
    check("flush_sb_empty", exp_q.size(), 0);
    exp_q.delete();

    // Same abort via n_clr.
    u0 = uf_cnt;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    ld_valid_i = 1'b1;
    ld_data_i  = {8'h0F, 8'hC1};
    ld_flip_i  = 1'b0;
    tick();
    ld_data_i = {8'h3C, 8'hA5};
    ld_flip_i = 1'b1;
    tick();
    tick();
    ld_valid_i = 1'b0;
    tick();
    n_clr = 1'b0;
    #1;
    check("rstab_valid", int'(pix_valid_o), 0);
    check("rstab_pix", int'(pix_o), 0);
    check("rstab_ready", int'(ld_ready_o), 1);
    check("rstab_underflow", int'(underflow_o), 0);
    @(negedge clk);
    #2;
    n_clr = 1'b1;
    repeat (12) tick();
    check("rstab_no_underflow", uf_cnt - u0, 0);
    check("rstab_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
